pet2001kbd: RTL and testbench
=============================

# pet2001kbd

Keyboard matrix responder for the PET emulator. Consumes the PS/2 scancode byte stream from the host-side PS/2 byte receiver, tracks make/break events in a 10×8 PET key matrix, and answers the I/O block's row scans. The I/O block drives `keyrow` from PIA1 port A and reads `keyin` on PIA1 port B.

## Interface
Parameters:
- `NUM_ROWS`, default 10. PET matrix rows; row selects of `NUM_ROWS` and above read as no key.
- `E1_SKIP`, default 7. Number of bytes discarded after an `E1` (Pause) prefix.

Ports:
- `clk` in 1. System clock. One clock; all state on the rising edge.
- `reset` in 1. Asynchronous, active-high. Clears all state.
- `kbd_data` in 8. Scancode byte from the PS/2 receiver.
- `kbd_strobe` in 1. One-cycle pulse; `kbd_data` valid in that cycle.
- `keyrow` in 4. Row select from PIA1 PA[3:0].
- `keyin` out 8. Column bits of the selected row, active-low (0 = pressed).

## Operation
- Matrix: 10×8 register bank `mtx[row][col]`, 1 = pressed.
- Prefix FSM. State advances only on `kbd_strobe`:
  - IDLE: `E0` → EXT. `F0` → BRK. `E1` → SKIP with counter = `E1_SKIP`. `AA` (BAT ok) → clear entire matrix, stay IDLE. Any other byte → make event {ext=0, code}, return IDLE.
  - EXT: `F0` → EXTBRK. `E0`/`E1` → IDLE, no event. Other byte → make event {ext=1, code} → IDLE.
  - BRK: `E0`/`E1`/`F0` → IDLE, no event. Other byte → break event {ext=0, code} → IDLE.
  - EXTBRK: `E0`/`E1`/`F0` → IDLE, no event. Other byte → break event {ext=1, code} → IDLE.
  - SKIP: each strobe decrements the counter. The strobe that brings the counter to 0 returns to IDLE. No events in SKIP.
- Event handling: {ext, code[7:0]} goes to the keymap lookup, which returns valid, row[3:0], col[2:0]. Valid make sets `mtx[row][col]`. Valid break clears it. Unmapped codes (valid=0) are ignored.
- Decided keymap entries (full table in package): `1C` → row 4 col 0 ('A'); `5A` → row 6 col 5 (RETURN); `12` → row 8 col 0 (left SHIFT); `E0 75` → row 1 col 7 (cursor up/down); `76` → row 9 col 4 (RUN/STOP).
- Repeated makes (typematic) for a pressed key are idempotent.
- Row readout: `keyrow` < `NUM_ROWS` → `keyin = ~mtx[keyrow]`. Otherwise `keyin = 8'hFF`.
- Multiple keys pressed in one row produce multiple 0 bits. No ghosting emulation.

## Timing
- Reset values: `keyin = 8'hFF`, FSM = IDLE, SKIP counter = 0, matrix all 0.
- Strobe in cycle N with final byte of an event: matrix bit updates at the edge ending N. The change is visible on `keyin` one cycle later, at the edge ending N+1, if that row is selected.
- `keyin` is registered. It reflects `keyrow` sampled at the previous edge, giving 1-cycle latency. The I/O block samples at CPU `ce` rate, so this latency is invisible to software.
- Bytes may arrive on consecutive cycles. The FSM must accept one byte per cycle with no drop.
- `AA` while in IDLE: the matrix clears at the same edge. `AA` in EXT/BRK/EXTBRK is treated as an ordinary code byte.
- Reset asserted mid-sequence (for example after `F0`): the FSM returns to IDLE and the matrix clears. The next byte is treated as a fresh make.
- `kbd_strobe` held high for several cycles is treated as one byte per cycle. This is a protocol violation upstream, and the block is not required to detect it.

## Structure
- Package `pet2001kbd_pkg`: FSM state enum (IDLE, EXT, BRK, EXTBRK, SKIP), prefix constants `E0`/`E1`/`F0`/`AA`, and the keymap table as a constant array indexed by {ext, code}.
- Sub-module `pet2001keymap`: purely combinational lookup, {ext, code} → valid/row/col. It is separately reusable by a future on-screen keyboard injector.
- Top level contains the FSM, SKIP counter, matrix bank and registered readout mux.

## Test plan
- Reset, then sweep `keyrow` 0–15 → `keyin = FF` for every row, including rows 10–15.
- Bytes `1C`, then `F0 1C`; hold `keyrow = 4` → `keyin = FE` two cycles after the `1C` strobe, then `FF` two cycles after the second `1C` strobe.
- `E0 75` with `keyrow = 1` → `keyin = 7F`. Then `E0 F0 75` → `FF`. Separately, a bare `75` with no mapping → row 1 unchanged.
- Press `12` and `5A`, then send `AA`, with `keyrow` = 8 and then 6 → `FE` and `DF` before `AA`, both `FF` after `AA`.
- `E1 14 77 E1 F0 14 F0 77` followed by `1C` → no matrix change during the 8 Pause bytes; row 4 reads `FE` after `1C`.
- `F0` followed by `reset` pulse, then `76` with `keyrow = 9` → `keyin = EF`, confirming the interrupted break was discarded.

Source files
------------

// File: rtl/pet2001kbd_pkg.sv
// Shared types, PS/2 prefix bytes and the PS/2-set-2 to PET matrix keymap.
// No timing: constants and constant functions only.
// No flow control: consumed by the responder FSM and the keymap lookup.
package pet2001kbd_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    EXT    = 3'd1,
    BRK    = 3'd2,
    EXTBRK = 3'd3,
    SKIP   = 3'd4
  } kbd_state_e;

  localparam logic [7:0] E0 = 8'hE0;  // extended-key prefix
  localparam logic [7:0] E1 = 8'hE1;  // Pause prefix
  localparam logic [7:0] F0 = 8'hF0;  // break prefix
  localparam logic [7:0] AA = 8'hAA;  // keyboard self-test passed

  typedef struct packed {
    logic       valid;
    logic [3:0] row;
    logic [2:0] col;
  } km_entry_t;

  // Indexed by {ext, code}: entries 0..255 plain codes, 256..511 E0 codes.
  typedef km_entry_t [511:0] km_table_t;

  function automatic km_entry_t km(input int row, input int col);
    km_entry_t e;
    e.valid = 1'b1;
    e.row   = 4'(row);
    e.col   = 3'(col);
    return e;
  endfunction

  // PET graphics keyboard layout; anything not listed reads as unmapped.
  function automatic km_table_t build_keymap();
    km_table_t t;
    t = '0;
    // row 0: HOME, cursor right
    t[9'h16C] = km(0, 6);  t[9'h174] = km(0, 7);
    // row 1: cursor up/down (both arrow keys share the PET key)
    t[9'h175] = km(1, 7);  t[9'h172] = km(1, 7);
    // row 2: Q E T U O, keypad 7 9
    t[9'h015] = km(2, 0);  t[9'h024] = km(2, 1);  t[9'h02C] = km(2, 2);
    t[9'h03C] = km(2, 3);  t[9'h044] = km(2, 4);
    t[9'h06C] = km(2, 6);  t[9'h07D] = km(2, 7);
    // row 3: W R Y I P
    t[9'h01D] = km(3, 0);  t[9'h02D] = km(3, 1);  t[9'h035] = km(3, 2);
    t[9'h043] = km(3, 3);  t[9'h04D] = km(3, 4);
    // row 4: A D G J L
    t[9'h01C] = km(4, 0);  t[9'h023] = km(4, 1);  t[9'h034] = km(4, 2);
    t[9'h03B] = km(4, 3);  t[9'h04B] = km(4, 4);
    // row 5: S F H K :
    t[9'h01B] = km(5, 0);  t[9'h02B] = km(5, 1);  t[9'h033] = km(5, 2);
    t[9'h042] = km(5, 3);  t[9'h04C] = km(5, 4);
    // row 6: Z C B M, RETURN
    t[9'h01A] = km(6, 0);  t[9'h021] = km(6, 1);  t[9'h032] = km(6, 2);
    t[9'h03A] = km(6, 3);  t[9'h05A] = km(6, 5);
    // row 7: X V N ,
    t[9'h022] = km(7, 0);  t[9'h02A] = km(7, 1);  t[9'h031] = km(7, 2);
    t[9'h041] = km(7, 3);
    // row 8: left SHIFT, right SHIFT
    t[9'h012] = km(8, 0);  t[9'h059] = km(8, 5);
    // row 9: SPACE, RUN/STOP
    t[9'h029] = km(9, 2);  t[9'h076] = km(9, 4);
    return t;
  endfunction

  localparam km_table_t KEYMAP = build_keymap();

endpackage

// File: rtl/pet2001kbd_if.sv
// Scancode input and PIA row-scan bundle for the keyboard matrix responder.
// keyin lags keyrow by one clock.
// No backpressure: kbd_strobe is a one-cycle push; every strobe is consumed.
interface pet2001kbd_if;
  logic [7:0] kbd_data;
  logic       kbd_strobe;
  logic [3:0] keyrow;
  logic [7:0] keyin;

  modport master (output kbd_data, output kbd_strobe, output keyrow, input keyin);
  modport slave  (input kbd_data, input kbd_strobe, input keyrow, output keyin);
endinterface

// File: rtl/pet2001kbd_keymap.sv
// Combinational PS/2 {ext, code} to PET matrix position lookup.
// Zero latency.
// No flow control; reusable by any key-event source.
module pet2001keymap
  import pet2001kbd_pkg::*;
(
  input  logic       ext,
  input  logic [7:0] code,
  output logic       valid,
  output logic [3:0] row,
  output logic [2:0] col
);

  km_entry_t entry;

  assign entry = KEYMAP[{ext, code}];
  assign valid = entry.valid;
  assign row   = entry.row;
  assign col   = entry.col;

endmodule

// File: rtl/pet2001kbd.sv
// PET keyboard matrix responder: PS/2 make/break bytes into a 10x8 key matrix.
// Matrix updates at the strobe edge; keyin is registered one clock after keyrow.
// No backpressure: one byte per cycle accepted, back-to-back strobes allowed.
module pet2001kbd
  import pet2001kbd_pkg::*;
#(
  parameter int NUM_ROWS = 10,
  parameter int E1_SKIP  = 7
) (
  input  logic         clk,
  input  logic         reset,
  pet2001kbd_if.slave  bus
);

  localparam int CW = (E1_SKIP < 2) ? 1 : $clog2(E1_SKIP + 1);

  localparam logic [2:0] S_IDLE   = IDLE;
  localparam logic [2:0] S_EXT    = EXT;
  localparam logic [2:0] S_BRK    = BRK;
  localparam logic [2:0] S_EXTBRK = EXTBRK;
  localparam logic [2:0] S_SKIP   = SKIP;

  logic [2:0]                state, state_nxt;
  logic [CW-1:0]             skip_cnt, skip_cnt_nxt;
  logic [NUM_ROWS-1:0][7:0]  mtx;
  logic                      ev_vld, ev_make, ev_ext, bat_clr;
  logic                      km_valid;
  logic [3:0]                km_row;
  logic [2:0]                km_col;
  logic                      is_prefix;

  assign is_prefix = (bus.kbd_data == E0) || (bus.kbd_data == E1) || (bus.kbd_data == F0);

  // Prefix decoder: turns each strobed byte into next state plus an optional key event.
  always_comb begin
    state_nxt    = state;
    skip_cnt_nxt = skip_cnt;
    ev_vld       = 1'b0;
    ev_make      = 1'b0;
    ev_ext       = 1'b0;
    bat_clr      = 1'b0;
    if (bus.kbd_strobe) begin
      case (state)
        S_IDLE: begin
          if (bus.kbd_data == E0) begin
            state_nxt = S_EXT;
          end else if (bus.kbd_data == F0) begin
            state_nxt = S_BRK;
          end else if (bus.kbd_data == E1) begin
            state_nxt    = S_SKIP;
            skip_cnt_nxt = CW'(E1_SKIP);
          end else if (bus.kbd_data == AA) begin
            bat_clr = 1'b1;
          end else begin
            ev_vld  = 1'b1;
            ev_make = 1'b1;
          end
        end
        S_EXT: begin
          state_nxt = S_IDLE;
          if (bus.kbd_data == F0) begin
            state_nxt = S_EXTBRK;
          end else if (!is_prefix) begin
            ev_vld  = 1'b1;
            ev_make = 1'b1;
            ev_ext  = 1'b1;
          end
        end
        S_BRK: begin
          state_nxt = S_IDLE;
          ev_vld    = !is_prefix;
        end
        S_EXTBRK: begin
          state_nxt = S_IDLE;
          ev_vld    = !is_prefix;
          ev_ext    = 1'b1;
        end
        S_SKIP: begin
          // The byte that takes the counter to zero is the last one swallowed.
          if (skip_cnt <= CW'(1)) begin
            state_nxt    = S_IDLE;
            skip_cnt_nxt = '0;
          end else begin
            skip_cnt_nxt = skip_cnt - CW'(1);
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  pet2001keymap u_keymap (
    .ext   (ev_ext),
    .code  (bus.kbd_data),
    .valid (km_valid),
    .row   (km_row),
    .col   (km_col)
  );

  // Prefix state and Pause skip counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      skip_cnt <= '0;
    end else begin
      state    <= state_nxt;
      skip_cnt <= skip_cnt_nxt;
    end
  end

  // Key matrix: BAT clears everything, mapped make/break sets/clears one bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mtx <= '0;
    end else if (bat_clr) begin
      mtx <= '0;
    end else if (ev_vld && km_valid && (32'(km_row) < NUM_ROWS)) begin
      mtx[km_row][km_col] <= ev_make;
    end
  end

  // Registered active-low row readout; unpopulated rows read as no key.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.keyin <= 8'hFF;
    end else if (32'(bus.keyrow) < NUM_ROWS) begin
      bus.keyin <= ~mtx[bus.keyrow];
    end else begin
      bus.keyin <= 8'hFF;
    end
  end

endmodule

// File: tb/tb_pet2001kbd.sv
// Self-checking bench for pet2001kbd: directed scenarios plus randomized
// key-token streams checked against a token-level matrix model.
module tb_pet2001kbd;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pet2001kbd_if bus();

  pet2001kbd #(.NUM_ROWS(10), .E1_SKIP(7)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef logic [7:0] bq_t[$];

  int n_chk  = 0;
  int n_pass = 0;

  // Expected pressed bits per row (1 = pressed); rows 10..15 never set.
  logic [7:0] model [16];

  // Keys the bench knows about: decided mappings plus a bare 75 (unmapped).
  int         k_ext  [6] = '{0, 0, 0, 0, 1, 0};
  logic [7:0] k_code [6] = '{8'h1C, 8'h5A, 8'h12, 8'h76, 8'h75, 8'h75};
  int         k_row  [6] = '{4, 6, 8, 9, 1, -1};
  int         k_col  [6] = '{0, 5, 0, 4, 7, 0};

  task automatic send_bytes(input bq_t q, input bit gaps);
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      if (i > 0 && gaps && $urandom_range(0, 1) == 1) begin
        bus.kbd_strobe = 1'b0;
        @(negedge clk);
      end
      bus.kbd_data   = q[i];
      bus.kbd_strobe = 1'b1;
    end
    @(negedge clk);
    bus.kbd_strobe = 1'b0;
  endtask

  task automatic read_row(input int r, output logic [7:0] v);
    @(negedge clk);
    bus.keyrow = 4'(r);
    @(negedge clk);
    v = bus.keyin;
  endtask

  task automatic test_reset();
    logic [7:0] v;
    bus.kbd_data   = 8'h00;
    bus.kbd_strobe = 1'b0;
    bus.keyrow     = 4'd0;
    reset          = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++;
    if (bus.keyin !== 8'hFF) $display("FAIL reset_keyin: got %02h want FF", bus.keyin);
    else n_pass++;
    reset = 1'b0;
    for (int r = 0; r < 16; r++) begin
      read_row(r, v);
      n_chk++;
      if (v !== 8'hFF) $display("FAIL reset_sweep row %0d: got %02h want FF", r, v);
      else n_pass++;
    end
  endtask

  task automatic test_make_break();
    logic [7:0] v;
    @(negedge clk); bus.keyrow = 4'd4;
    @(negedge clk); bus.kbd_data = 8'h1C; bus.kbd_strobe = 1'b1;
    @(negedge clk); bus.kbd_strobe = 1'b0;
    n_chk++;
    if (bus.keyin !== 8'hFF) $display("FAIL make_latency_early: got %02h want FF", bus.keyin);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (bus.keyin !== 8'hFE) $display("FAIL make_latency: got %02h want FE", bus.keyin);
    else n_pass++;
    // typematic repeats must leave the key pressed once
    send_bytes('{8'h1C, 8'h1C, 8'h1C}, 1'b0);
    read_row(4, v);
    n_chk++;
    if (v !== 8'hFE) $display("FAIL typematic: got %02h want FE", v);
    else n_pass++;
    @(negedge clk); bus.kbd_data = 8'hF0; bus.kbd_strobe = 1'b1;
    @(negedge clk); bus.kbd_data = 8'h1C;
    @(negedge clk); bus.kbd_strobe = 1'b0;
    n_chk++;
    if (bus.keyin !== 8'hFE) $display("FAIL break_latency_early: got %02h want FE", bus.keyin);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (bus.keyin !== 8'hFF) $display("FAIL break_latency: got %02h want FF", bus.keyin);
    else n_pass++;
  endtask

  task automatic test_ext();
    logic [7:0] v;
    send_bytes('{8'hE0, 8'h75}, 1'b0);
    read_row(1, v);
    n_chk++;
    if (v !== 8'h7F) $display("FAIL ext_make: got %02h want 7F", v);
    else n_pass++;
    send_bytes('{8'hE0, 8'hF0, 8'h75}, 1'b0);
    read_row(1, v);
    n_chk++;
    if (v !== 8'hFF) $display("FAIL ext_break: got %02h want FF", v);
    else n_pass++;
    send_bytes('{8'h75}, 1'b0);
    read_row(1, v);
    n_chk++;
    if (v !== 8'hFF) $display("FAIL bare_75_unmapped: got %02h want FF", v);
    else n_pass++;
  endtask

  task automatic test_bat();
    logic [7:0] v;
    send_bytes('{8'h12, 8'h5A}, 1'b0);
    read_row(8, v);
    n_chk++;
    if (v !== 8'hFE) $display("FAIL bat_pre_row8: got %02h want FE", v);
    else n_pass++;
    read_row(6, v);
    n_chk++;
    if (v !== 8'hDF) $display("FAIL bat_pre_row6: got %02h want DF", v);
    else n_pass++;
    send_bytes('{8'hAA}, 1'b0);
    read_row(8, v);
    n_chk++;
    if (v !== 8'hFF) $display("FAIL bat_post_row8: got %02h want FF", v);
    else n_pass++;
    read_row(6, v);
    n_chk++;
    if (v !== 8'hFF) $display("FAIL bat_post_row6: got %02h want FF", v);
    else n_pass++;
    // AA after a prefix is just a code byte and must not clear the matrix
    send_bytes('{8'h1C, 8'hF0, 8'hAA, 8'hE0, 8'hAA}, 1'b0);
    read_row(4, v);
    n_chk++;
    if (v !== 8'hFE) $display("FAIL aa_after_prefix: got %02h want FE", v);
    else n_pass++;
    send_bytes('{8'hF0, 8'h1C}, 1'b0);
  endtask

  task automatic test_pause();
    logic [7:0] v;
    send_bytes('{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77}, 1'b0);
    read_row(4, v);
    n_chk++;
    if (v !== 8'hFF) $display("FAIL pause_no_change: got %02h want FF", v);
    else n_pass++;
    send_bytes('{8'h1C}, 1'b0);
    read_row(4, v);
    n_chk++;
    if (v !== 8'hFE) $display("FAIL pause_then_make: got %02h want FE", v);
    else n_pass++;
    // exactly seven bytes swallowed: the seventh 1C must not count, the 5A must
    send_bytes('{8'hF0, 8'h1C, 8'hE1, 8'h1C, 8'h1C, 8'h1C, 8'h1C, 8'h1C, 8'h1C, 8'h1C, 8'h5A}, 1'b0);
    read_row(4, v);
    n_chk++;
    if (v !== 8'hFF) $display("FAIL pause_skip_count: got %02h want FF", v);
    else n_pass++;
    read_row(6, v);
    n_chk++;
    if (v !== 8'hDF) $display("FAIL pause_skip_end: got %02h want DF", v);
    else n_pass++;
    send_bytes('{8'hF0, 8'h5A}, 1'b0);
  endtask

  task automatic test_reset_mid();
    logic [7:0] v;
    send_bytes('{8'h1C, 8'hF0}, 1'b0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    n_chk++;
    if (bus.keyin !== 8'hFF) $display("FAIL mid_reset_keyin: got %02h want FF", bus.keyin);
    else n_pass++;
    reset = 1'b0;
    send_bytes('{8'h76}, 1'b0);
    read_row(9, v);
    n_chk++;
    if (v !== 8'hEF) $display("FAIL mid_reset_fresh_make: got %02h want EF", v);
    else n_pass++;
    read_row(4, v);
    n_chk++;
    if (v !== 8'hFF) $display("FAIL mid_reset_cleared: got %02h want FF", v);
    else n_pass++;
    send_bytes('{8'hF0, 8'h76}, 1'b0);
  endtask

  task automatic test_random();
    logic [7:0] v, exp_v;
    bq_t q;
    int  t, k, r;
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    send_bytes('{8'hAA}, 1'b0);
    for (int n = 0; n < 60; n++) begin
      q.delete();
      t = $urandom_range(0, 19);
      k = $urandom_range(0, 5);
      if (t <= 7) begin
        if (k_ext[k] != 0) q.push_back(8'hE0);
        q.push_back(k_code[k]);
        if (k_row[k] >= 0) model[k_row[k]][k_col[k]] = 1'b1;
      end else if (t <= 14) begin
        if (k_ext[k] != 0) q.push_back(8'hE0);
        q.push_back(8'hF0);
        q.push_back(k_code[k]);
        if (k_row[k] >= 0) model[k_row[k]][k_col[k]] = 1'b0;
      end else if (t == 15) begin
        q.push_back(8'hAA);
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
      end else if (t == 16) begin
        q.push_back(8'hE1);
        for (int i = 0; i < 7; i++) q.push_back(8'($urandom));
      end else begin
        case (k)
          0: begin q.push_back(8'hE0); q.push_back(8'hE0); end
          1: begin q.push_back(8'hE0); q.push_back(8'hE1); end
          2: begin q.push_back(8'hF0); q.push_back(8'hF0); end
          3: begin q.push_back(8'hF0); q.push_back(8'hE0); end
          4: begin q.push_back(8'hF0); q.push_back(8'hE1); end
          default: begin q.push_back(8'hE0); q.push_back(8'hF0); q.push_back(8'hE0); end
        endcase
      end
      send_bytes(q, 1'b1);
      r = $urandom_range(0, 15);
      exp_v = (r < 10) ? ~model[r] : 8'hFF;
      read_row(r, v);
      n_chk++;
      if (v !== exp_v) $display("FAIL random token %0d row %0d: got %02h want %02h", n, r, v, exp_v);
      else n_pass++;
    end
    for (int rr = 0; rr < 16; rr++) begin
      exp_v = (rr < 10) ? ~model[rr] : 8'hFF;
      read_row(rr, v);
      n_chk++;
      if (v !== exp_v) $display("FAIL random_sweep row %0d: got %02h want %02h", rr, v, exp_v);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_make_break();
    test_ext();
    test_bat();
    test_pause();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached after %0d checks", n_chk);
    $fatal(1);
  end

endmodule
